// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature decoder: AB state encodings, direction
// codes, the INIT/RUN mode and the edge classifier used by the decode stage.
package enc_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  localparam logic DIR_A_LEAD = 1'b0;
  localparam logic DIR_B_LEAD = 1'b1;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Filter stability counter covers FILT_LEN up to 15.
  localparam int FILT_CNT_W = 4;
  // INIT counter covers FILT_LEN+2 up to 17 cycles.
  localparam int INIT_CNT_W = 5;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MV_NONE    = 2'd0,
    MV_UP      = 2'd1,
    MV_DOWN    = 2'd2,
    MV_ILLEGAL = 2'd3
  } move_t;

  // Successor of an AB state when A leads B.
  function automatic logic [1:0] step_up(input logic [1:0] ab);
    logic [1:0] nxt;
    nxt = QS_00;
    case (ab)
      QS_00:   nxt = QS_10;
      QS_10:   nxt = QS_11;
      QS_11:   nxt = QS_01;
      default: nxt = QS_00;
    endcase
    return nxt;
  endfunction

  function automatic move_t classify(input logic [1:0] prev, input logic [1:0] cur);
    move_t mv;
    if (prev == cur)                mv = MV_NONE;
    else if (cur == step_up(prev))  mv = MV_UP;
    else if (prev == step_up(cur))  mv = MV_DOWN;
    else                            mv = MV_ILLEGAL;
    return mv;
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// One encoder line: two-flop synchronizer followed by a stability filter that
// only adopts a new level after it has been seen for FILT_LEN consecutive clocks.
module enc_glitch_filter
  import enc_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic init_load,
  output logic filt
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic                  sync1;
  logic                  sync2;
  logic [FILT_CNT_W-1:0] cnt;

  // NOTE: state updates use <= so every flop samples pre-edge values; blocking
  // here would let sync2 see this cycle's sync1 and collapse the synchronizer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      filt  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (init_load) begin
        // Track the line directly so power-up levels never look like an edge.
        filt <= sync2;
        cnt  <= '0;
      end else if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_quad_decoder.sv
// Quadrature front end: filtered A/B, 4x decode into a position counter with
// preload, direction, per-edge tick and sticky illegal-transition/wrap flags.
module enc_quad_decoder
  import enc_pkg::*;
#(
  parameter int               FILT_LEN = 4,
  parameter int               CNT_W    = 24,
  parameter logic [CNT_W-1:0] PRELOAD  = 24'h800000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_raw,
  input  logic             b_raw,
  input  logic             preload_en,
  input  logic [CNT_W-1:0] preload_val,
  input  logic             clr_err,
  output logic             a_filt,
  output logic             b_filt,
  output logic             dir,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic             ovf
);

  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(FILT_LEN + 1);

  state_t                  state;
  logic [INIT_CNT_W-1:0]   init_cnt;
  logic                    init_load;
  logic [1:0]              prev_ab;
  logic [1:0]              cur_ab;
  move_t                   move;
  logic [CNT_W-1:0]        count_nxt;
  logic                    wrap;
  logic                    illegal;

  assign init_load = (state == INIT);
  assign cur_ab    = {a_filt, b_filt};
  assign illegal   = (move == MV_ILLEGAL);

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk       (clk),
    .reset     (reset),
    .raw       (a_raw),
    .init_load (init_load),
    .filt      (a_filt)
  );

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk       (clk),
    .reset     (reset),
    .raw       (b_raw),
    .init_load (init_load),
    .filt      (b_filt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      if (init_cnt == INIT_LAST) begin
        state    <= RUN;
        init_cnt <= '0;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    move      = MV_NONE;
    count_nxt = count;
    wrap      = 1'b0;
    if (state == RUN) begin
      move = classify(prev_ab, cur_ab);
    end
    case (move)
      MV_UP: begin
        count_nxt = count + 1'b1;
        wrap      = &count;
      end
      MV_DOWN: begin
        count_nxt = count - 1'b1;
        wrap      = (count == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_ab <= QS_00;
      tick    <= 1'b0;
      dir     <= DIR_A_LEAD;
      count   <= PRELOAD;
      err     <= 1'b0;
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      tick    <= (move == MV_UP) || (move == MV_DOWN);

      if (move == MV_UP)        dir <= DIR_A_LEAD;
      else if (move == MV_DOWN) dir <= DIR_B_LEAD;

      // A preload wins the count; a coincident edge still reports dir/tick.
      count <= preload_en ? preload_val : count_nxt;

      if (wrap && !preload_en) ovf <= 1'b1;
      else if (clr_err)        ovf <= 1'b0;

      if (illegal)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;

      if (illegal && (err_cnt != ERR_CNT_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_enc_quad_decoder.sv
// Scoreboard bench for enc_quad_decoder: each driven quadrature step queues the
// tick it must produce (cycle, count, dir); a monitor pops and compares ticks.
module tb_enc_quad_decoder;

  localparam int FILT_LEN = 4;
  localparam int CNT_W    = 24;
  localparam logic [CNT_W-1:0] PRELOAD = 24'h800000;
  localparam int TICK_LAT = FILT_LEN + 3;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] cnt;
    logic             dir;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_raw;
  logic             b_raw;
  logic             preload_en;
  logic [CNT_W-1:0] preload_val;
  logic             clr_err;
  logic             a_filt;
  logic             b_filt;
  logic             dir;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             err;
  logic [7:0]       err_cnt;
  logic             ovf;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  exp_t sb[$];

  logic             a_lv;
  logic             b_lv;
  logic [CNT_W-1:0] exp_count;
  logic             exp_dir;
  logic [7:0]       exp_err_cnt;
  logic             exp_ovf;

  enc_quad_decoder #(
    .FILT_LEN (FILT_LEN),
    .CNT_W    (CNT_W),
    .PRELOAD  (PRELOAD)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .preload_en  (preload_en),
    .preload_val (preload_val),
    .clr_err     (clr_err),
    .a_filt      (a_filt),
    .b_filt      (b_filt),
    .dir         (dir),
    .tick        (tick),
    .count       (count),
    .err         (err),
    .err_cnt     (err_cnt),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Gray position of an AB level; forward steps are +1 mod 4.
  function automatic int gpos(input logic a, input logic b);
    int p;
    case ({a, b})
      2'b00:   p = 0;
      2'b10:   p = 1;
      2'b11:   p = 2;
      default: p = 3;
    endcase
    return p;
  endfunction

  task automatic model_reset();
    exp_count   = PRELOAD;
    exp_dir     = 1'b0;
    exp_err_cnt = 8'd0;
    exp_ovf     = 1'b0;
  endtask

  // Record the effect of moving the filtered lines to (a,b) and queue any tick.
  task automatic model_step(input logic a, input logic b, input bit pl, input logic [CNT_W-1:0] plv);
    int   d;
    exp_t e;
    d = (gpos(a, b) - gpos(a_lv, b_lv) + 4) % 4;
    if (d == 1) begin
      if (exp_count == {CNT_W{1'b1}} && !pl) exp_ovf = 1'b1;
      exp_count = pl ? plv : exp_count + 1'b1;
      exp_dir   = 1'b0;
    end else if (d == 3) begin
      if (exp_count == '0 && !pl) exp_ovf = 1'b1;
      exp_count = pl ? plv : exp_count - 1'b1;
      exp_dir   = 1'b1;
    end else if (d == 2) begin
      if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
      if (pl) exp_count = plv;
    end else if (pl) begin
      exp_count = plv;
    end
    if (d == 1 || d == 3) begin
      e.cyc = cyc + TICK_LAT;
      e.cnt = exp_count;
      e.dir = exp_dir;
      sb.push_back(e);
    end
    a_lv = a;
    b_lv = b;
  endtask

  // Drive a new raw level and hold it; optional preload/clr land in the decode cycle.
  task automatic drive_ab(input logic a, input logic b, input int hold,
                          input bit pl = 1'b0, input logic [CNT_W-1:0] plv = '0,
                          input bit clr = 1'b0);
    int c;
    model_step(a, b, pl, plv);
    a_raw = a;
    b_raw = b;
    c = cyc;
    repeat (hold) begin
      @(negedge clk);
      preload_val = plv;
      preload_en  = pl  && (cyc == c + TICK_LAT - 1);
      clr_err     = clr && (cyc == c + TICK_LAT - 1);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    exp_ovf = 1'b0;
  endtask

  task automatic do_preload(input logic [CNT_W-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
    @(negedge clk);
    exp_count = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_filt"},  a_filt,  0);
    check({tag, "_b_filt"},  b_filt,  0);
    check({tag, "_dir"},     dir,     0);
    check({tag, "_tick"},    tick,    0);
    check({tag, "_count"},   count,   PRELOAD);
    check({tag, "_err"},     err,     0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_ovf"},     ovf,     0);
  endtask

  // Tick monitor: every tick must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && tick === 1'b1) begin
      if (sb.size() == 0) begin
        check("tick_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_count", count, e.cnt);
        check("tick_dir",   dir,   e.dir);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    a_raw       = 1'b1;
    b_raw       = 1'b1;
    preload_en  = 1'b0;
    preload_val = '0;
    clr_err     = 1'b0;
    model_reset();

    // Reset with both lines high; INIT must adopt them without a tick.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    a_lv  = 1'b1;
    b_lv  = 1'b1;
    repeat (3) @(negedge clk);
    check("init_direct_load_a", a_filt, 1);
    repeat (3) @(negedge clk);
    check("init_a_filt", a_filt, 1);
    check("init_b_filt", b_filt, 1);
    check("init_count",  count,  PRELOAD);
    check("init_err",    err,    0);
    repeat (4) @(negedge clk);
    check("init_no_tick_count", count, PRELOAD);

    // Restart from 00 lines for the clean forward sequence.
    reset = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    a_lv = 1'b0;
    b_lv = 1'b0;
    repeat (10) @(negedge clk);

    drive_ab(1'b1, 1'b0, 10);
    drive_ab(1'b1, 1'b1, 10);
    drive_ab(1'b0, 1'b1, 10);
    drive_ab(1'b0, 1'b0, 10);
    check("fwd_count", count, exp_count);
    check("fwd_dir",   dir,   0);

    // Glitch of FILT_LEN-1 clocks must be swallowed.
    a_raw = 1'b1;
    repeat (FILT_LEN - 1) @(negedge clk);
    a_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("glitch_a_filt", a_filt, 0);
      @(negedge clk);
    end
    check("glitch_count", count, exp_count);

    // A pulse of exactly FILT_LEN clocks passes: one step up then back down.
    a_raw = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, '0);
    repeat (FILT_LEN) @(negedge clk);
    a_raw = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, '0);
    repeat (12) @(negedge clk);
    check("pulse_count", count, exp_count);
    check("pulse_dir",   dir,   1);

    // Illegal double change, then clear; err_cnt survives clr_err.
    drive_ab(1'b1, 1'b1, 10);
    check("ill_err",     err,     1);
    check("ill_err_cnt", err_cnt, exp_err_cnt);
    check("ill_count",   count,   exp_count);
    check("ill_dir",     dir,     1);
    pulse_clr();
    check("clr_err",         err,     0);
    check("clr_err_cnt_kept", err_cnt, 1);

    for (int i = 0; i < 300; i++) drive_ab(~a_lv, ~b_lv, 8);
    check("sat_err_cnt", err_cnt, 8'd255);
    check("sat_model",   err_cnt, exp_err_cnt);
    check("sat_err",     err,     1);
    pulse_clr();
    check("sat_clr_err", err, 0);

    // clr_err coinciding with an illegal edge: the set wins.
    drive_ab(~a_lv, ~b_lv, 10, 1'b0, '0, 1'b1);
    check("set_wins_err", err, 1);

    // Preload 0 then a reverse step wraps to all ones.
    do_preload('0);
    check("preload_zero", count, 0);
    drive_ab(1'b0, 1'b1, 10);
    check("wrap_count", count, {CNT_W{1'b1}});
    check("wrap_ovf",   ovf,   exp_ovf);
    check("wrap_dir",   dir,   1);

    // Preload in the same cycle as a forward edge: tick still fires, count=5.
    drive_ab(1'b0, 1'b0, 10, 1'b1, 24'd5);
    check("pl_edge_count", count, 5);
    check("pl_edge_dir",   dir,   0);
    check("pl_edge_ovf",   ovf,   1);
    pulse_clr();
    check("clr_ovf", ovf, 0);

    // Reach 0x800010, then reset asynchronously mid-cycle.
    do_preload(24'h80000E);
    drive_ab(1'b1, 1'b0, 10);
    drive_ab(1'b1, 1'b1, 10);
    check("pre_reset_count", count, 24'h800010);
    #1;
    reset = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    a_lv = 1'b1;
    b_lv = 1'b0;
    repeat (8) @(negedge clk);
    check("reinit_a_filt", a_filt, 1);
    check("reinit_b_filt", b_filt, 0);
    check("reinit_count",  count,  PRELOAD);
    drive_ab(1'b1, 1'b1, 10);
    check("post_reinit_count", count, exp_count);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc_quad_decoder.md
Name: enc_quad_decoder

Overview:
- Upstream stage of the encoder period measurement block.
- Synchronizes and glitch-filters raw quadrature lines A/B and performs 4x quadrature decode.
- Maintains a signed-agnostic position counter with preload, and flags illegal transitions.
- Outputs clean a_filt/b_filt, dir and a one-cycle tick; the period-measurement stage uses these as its a/b/dir inputs.

Parameters:
FILT_LEN, 4, consecutive clk samples a new synchronized level must hold before a_filt/b_filt adopt it (range 1..15)
CNT_W, 24, position counter width
PRELOAD, 24'h800000, counter value loaded at reset

Ports:
clk  in  1  system clock (sysclk)
reset  in  1  asynchronous, active-low reset
a_raw  in  1  raw encoder line A (asynchronous to clk)
b_raw  in  1  raw encoder line B (asynchronous to clk)
preload_en  in  1  load preload_val into count this cycle
preload_val  in  CNT_W  value to load
clr_err  in  1  clear err and ovf sticky flags
a_filt  out  1  filtered A
b_filt  out  1  filtered B
dir  out  1  0 = A leading B (count up), 1 = B leading A (count down)
tick  out  1  one-clk pulse per valid decoded edge
count  out  CNT_W  position count
err  out  1  sticky; set on illegal transition (A and B change together)
err_cnt  out  8  illegal-transition count, saturating at 255
ovf  out  1  sticky; set on count wrap in either direction

Behaviour:
- Reset values (async, reset==0): sync flops 0; a_filt=b_filt=0; dir=0; tick=0; count=PRELOAD; err=0; err_cnt=0; ovf=0; FSM=INIT; filter counters 0.
- Synchronizer: two flops per line; sync2 is the filter input.
- FSM INIT: a_filt/b_filt load sync2 directly every cycle. An init counter runs FILT_LEN+2 cycles, then the FSM moves to RUN. No tick, count, dir or err activity in INIT. This prevents a false edge from non-zero line levels at reset.
- FSM RUN filter, per channel:
  - If sync2 != filt, the filter counter increments.
  - When the counter is FILT_LEN-1 and sync2 still != filt, filt <= sync2 on the next edge and the counter clears.
  - If sync2 == filt at any point, the counter clears.
  - Latency: a raw change registered into sync1 at edge k gives a filt change at edge k+1+FILT_LEN.
  - A pulse shorter than FILT_LEN clks never reaches the filt outputs.
- Decode, registered, one clk after a filt change. prev={a_filt,b_filt} of the previous cycle, cur=current.
  - dir=0 sequence (AB): 00->10->11->01->00. Each step: count+1, dir<=0, tick=1.
  - dir=1 sequence: the reverse. Each step: count-1, dir<=1, tick=1.
  - Both bits change together: illegal. count and dir hold, tick=0, err<=1, err_cnt+1 saturating at 255.
  - No change: tick=0.
- Wrap: count is modulo 2^CNT_W.
  - Up from all-ones gives 0; down from 0 gives all-ones.
  - Either wrap sets ovf.
- Preload: preload_en has priority over decode for count.
  - count<=preload_val in the same cycle.
  - A simultaneous valid edge still updates dir and pulses tick, but its increment is discarded.
  - A preload arriving during INIT is honoured.
- clr_err clears err and ovf; err_cnt is not cleared by clr_err. If a set event occurs in the same cycle, the set wins.
- Reset asserted mid-operation returns everything to reset values immediately, including a restart of INIT.

Decomposition:
- Package enc_pkg:
  - quadrature state constants (2-bit AB);
  - DIR_A_LEAD=0 and DIR_B_LEAD=1;
  - FSM enum {INIT, RUN};
  - ERR_CNT_MAX=8'd255.
- Sub-module enc_glitch_filter (synchronizer plus stability counter plus init-load input), instantiated once per channel.
- Decode, counter and flags live in the top.

Test Plan:
- Reset with a_raw=b_raw=1 held, release -> a_filt=b_filt=1 after INIT (FILT_LEN+2=6 clks); no tick; count=24'h800000; err=0.
- Four clean dir-0 edges (00->10->11->01->00), each level held 10 clks -> 4 ticks; count=24'h800004; dir=0. Tick appears exactly FILT_LEN+3 clks after the raw edge.
- 3-clk glitch on a_raw (FILT_LEN=4) -> a_filt unchanged; no tick; count unchanged.
- Toggle a_raw and b_raw in the same clk from 00 to 11 -> err=1; err_cnt=1; count and dir unchanged. Then clr_err=1 -> err=0, err_cnt stays 1. Repeat 300 times -> err_cnt=255.
- preload_val=0, preload_en, then one dir-1 edge -> count=24'hFFFFFF, ovf=1, dir=1. Also assert preload_en=1 with preload_val=5 in the same clk as a dir-0 edge -> count=5, tick=1.
- Assert reset mid-stream after count=24'h800010 -> all outputs return to reset values asynchronously, and INIT is re-run on release.
